wb_register_file: RTL
=====================

Name: wb_register_file

Overview:
- Architectural register file of the pipelined MIPS core; consumer end of the writeback path.
- Accepts the writeback result (resultW, writeRegW, regWriteW) and serves the two decode-stage read ports.
- Internal write-to-read bypass gives same-cycle visibility of the writeback value, so decode needs no separate WB->D forwarding.
- Also provides a debug read port and write-activity bookkeeping for the bench and for lab inspection.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers. Address width is log2(NREG) = 5.
- CNTW, 16, width of the writes-retired counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- regWriteW  input  1  writeback write enable.
- writeRegW  input  5  destination register of writeback.
- resultW  input  WIDTH  writeback data.
- A1  input  5  read address, port 1 (rs).
- A2  input  5  read address, port 2 (rt).
- RD1  output  WIDTH  read data, port 1.
- RD2  output  WIDTH  read data, port 2.
- dbgAddr  input  5  debug read address.
- dbgData  output  WIDTH  debug read data (registered).
- writeCount  output  CNTW  number of committed writes since reset.
- lastWriteReg  output  5  destination of the most recent committed write.
- lastWriteValid  output  1  high once any write has been committed since reset.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - All NREG registers clear to 0.
  - dbgData = 0, writeCount = 0, lastWriteReg = 0, lastWriteValid = 0.
  - Deassertion takes effect at the next rising edge. No reset-release FSM; the block is fully usable on the first edge after release.
  - Reset asserted mid-cycle discards any in-flight write. Reset dominates a simultaneous write.
- Committed write: regWriteW = 1 and writeRegW != 0 at a rising edge.
  - Register[writeRegW] <= resultW.
  - writeCount <= writeCount + 1.
  - lastWriteReg <= writeRegW.
  - lastWriteValid <= 1.
- Register 0:
  - Hardwired zero. A write to address 0 is ignored and is not counted.
  - Reads of address 0 always return 0, including under bypass.
- Read ports (combinational, zero latency):
  - RDn = resultW when regWriteW = 1, writeRegW == An and An != 0 (bypass).
  - Otherwise RDn = Register[An].
  - Both ports are independent. A1 == A2 is legal, and both ports return the same value, including when bypassed.
- Debug port:
  - dbgData <= Register[dbgAddr] at each rising edge (one-cycle latency, pre-write value).
  - No bypass on this port. A write to dbgAddr in the same edge appears on dbgData one cycle later.
- writeCount wraps modulo 2^CNTW; there is no saturation flag.
- Back-to-back writes to the same register are legal. The last write wins, and each write is counted.
- X on writeRegW while regWriteW = 0 must not corrupt state. X on regWriteW is a bench error.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle after writing 0xDEADBEEF to r5 -> r5, dbgData and writeCount read 0 immediately. With rst_n held 0 and regWriteW = 1, no write commits.
- Basic write/read: write r8 = 0x12345678, then set A1 = 8, A2 = 9 next cycle -> RD1 = 0x12345678, RD2 = 0, writeCount = 1, lastWriteReg = 8, lastWriteValid = 1.
- Bypass: drive regWriteW = 1, writeRegW = 3, resultW = 0xA5A5A5A5 with A1 = A2 = 3 before the edge -> RD1 = RD2 = 0xA5A5A5A5 combinationally. After the edge, with regWriteW = 0, both ports still read 0xA5A5A5A5.
- Zero register: write r0 = 0xFFFFFFFF with A1 = 0 -> RD1 = 0 before and after the edge, and writeCount is unchanged.
- Debug latency: write r12 = 7 at edge N with dbgAddr = 12 -> dbgData = old value (0) after edge N, and 7 after edge N+1.
- Counter wrap (CNTW = 4 in test build): commit 17 writes to r1..r17 -> writeCount = 1, lastWriteReg = 17, and each register holds its written value.

Source files
------------

// File: rtl/wb_register_file.sv
// Architectural register file of the pipelined MIPS core, at the consumer end
// of the writeback path. It has two combinational read ports with a
// write-to-read bypass, a registered debug read port, and write-activity
// bookkeeping: a wrapping commit counter and the last destination written.
module wb_register_file #(
    parameter  int WIDTH = 32,
    parameter  int NREG  = 32,
    parameter  int CNTW  = 16,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    // writeback interface
    input  logic             regWriteW,
    input  logic [AW-1:0]    writeRegW,
    input  logic [WIDTH-1:0] resultW,
    // decode-stage read ports
    input  logic [AW-1:0]    A1,
    input  logic [AW-1:0]    A2,
    output logic [WIDTH-1:0] RD1,
    output logic [WIDTH-1:0] RD2,
    // debug / lab inspection
    input  logic [AW-1:0]    dbgAddr,
    output logic [WIDTH-1:0] dbgData,
    output logic [CNTW-1:0]  writeCount,
    output logic [AW-1:0]    lastWriteReg,
    output logic             lastWriteValid
);

    // Architectural state. Entry 0 is kept at zero so that it reads back as
    // zero without any special case in the debug path.
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    logic [WIDTH-1:0] dbg_data_q,        dbg_data_d;
    logic [CNTW-1:0]  write_count_q,     write_count_d;
    logic [AW-1:0]    last_write_reg_q,  last_write_reg_d;
    logic             last_write_valid_q, last_write_valid_d;

    // A write commits only with the enable high and a non-zero destination.
    // Testing regWriteW first keeps an X on writeRegW harmless while idle.
    logic commit;
    assign commit = regWriteW && (writeRegW != '0);

    // Next-state for the register array: only the addressed entry changes.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch;
        // otherwise a path that skips the assignment infers a latch.
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            for (int i = 1; i < NREG; i++) begin
                if (writeRegW == AW'(i)) begin
                    regs_d[i] = resultW;
                end
            end
        end
        regs_d[0] = '0;
    end

    // Next-state for bookkeeping and the debug port.
    always_comb begin
        write_count_d      = write_count_q;
        last_write_reg_d   = last_write_reg_q;
        last_write_valid_d = last_write_valid_q;
        // The debug port samples the pre-write contents; it has no bypass.
        dbg_data_d         = regs_q[dbgAddr];
        if (commit) begin
            // Counter wraps modulo 2^CNTW by plain overflow.
            write_count_d      = write_count_q + 1'b1;
            last_write_reg_d   = writeRegW;
            last_write_valid_d = 1'b1;
        end
    end

    // Register array update; reset clears every entry and dominates a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is architectural state that must read as zero
            // after reset, so it is reset explicitly; a plain data RAM would
            // normally be left unreset so it can map to memory macros.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Bookkeeping and debug data flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_data_q         <= '0;
            write_count_q      <= '0;
            last_write_reg_q   <= '0;
            last_write_valid_q <= 1'b0;
        end else begin
            dbg_data_q         <= dbg_data_d;
            write_count_q      <= write_count_d;
            last_write_reg_q   <= last_write_reg_d;
            last_write_valid_q <= last_write_valid_d;
        end
    end

    // Read port 1: bypass the writeback value, and force address 0 to zero.
    always_comb begin
        RD1 = regs_q[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (regWriteW && (writeRegW == A1)) begin
            RD1 = resultW;
        end
    end

    // Read port 2: identical to port 1 and independent of it.
    always_comb begin
        RD2 = regs_q[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (regWriteW && (writeRegW == A2)) begin
            RD2 = resultW;
        end
    end

    assign dbgData        = dbg_data_q;
    assign writeCount     = write_count_q;
    assign lastWriteReg   = last_write_reg_q;
    assign lastWriteValid = last_write_valid_q;

endmodule
